// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operation request in, registered result
// and status flags out, each direction with its own valid/ready pair.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       Sel_i;
    logic [WIDTH-1:0] D0_i;
    logic [WIDTH-1:0] D1_i;
    logic             Valid_i;
    logic             Ready_o;
    logic [WIDTH-1:0] Q_o;
    logic             Valid_o;
    logic             Ready_i;
    logic             Carry_o;
    logic             Zero_o;
    logic             Ovf_o;
    logic             Err_o;

    // Requester / result consumer side.
    modport master (
        output Sel_i, D0_i, D1_i, Valid_i, Ready_i,
        input  Ready_o, Q_o, Valid_o, Carry_o, Zero_o, Ovf_o, Err_o
    );

    // ALU side.
    modport slave (
        input  Sel_i, D0_i, D1_i, Valid_i, Ready_i,
        output Ready_o, Q_o, Valid_o, Carry_o, Zero_o, Ovf_o, Err_o
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle pass/add/sub/shift ops, a WIDTH-cycle
// shift-add multiplier, and a result register held until the consumer
// takes it. One request in flight at a time.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rstn,
    seq_alu_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Multiplier working registers: double-width accumulator and multiplicand.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    // Result and flag registers presented on the bus.
    logic [WIDTH-1:0] q;
    logic             carry, zero, ovf, err;

    logic             accept, mul_start, alu_load, mul_last;
    logic             ready, valid;
    logic [WIDTH-1:0] alu_q;
    logic             alu_carry, alu_err;
    logic [WIDTH:0]   sum, diff;

    assign accept    = (state == IDLE) && bus.Valid_i;
    assign mul_start = accept && (bus.Sel_i == 3'd2);
    assign alu_load  = accept && (bus.Sel_i != 3'd2);
    // All WIDTH multiplier bits consumed; this cycle moves the product out.
    assign mul_last  = (state == MUL) && (cnt == CNT_W'(WIDTH));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.Valid_i) state_nxt = (bus.Sel_i == 3'd2) ? MUL : DONE;
            MUL:     if (mul_last)    state_nxt = DONE;
            DONE:    if (bus.Ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        ready = (state == IDLE);
        valid = (state == DONE);
    end

    // Single-cycle operations evaluated on the live request inputs.
    always_comb begin
        sum       = {1'b0, bus.D0_i} + {1'b0, bus.D1_i};
        diff      = {1'b0, bus.D0_i} - {1'b0, bus.D1_i};
        alu_q     = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (bus.Sel_i)
            3'd0: alu_q = bus.D0_i;
            3'd1: begin
                alu_q     = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            3'd3: begin
                // Top bit of the widened difference is the unsigned borrow.
                alu_q     = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
            end
            3'd4:       alu_q = bus.D0_i << bus.D1_i[SHW-1:0];
            3'd5:       alu_q = bus.D0_i >> bus.D1_i[SHW-1:0];
            3'd6, 3'd7: alu_err = 1'b1;
            default:    alu_q = '0;
        endcase
    end

    // Shift-add multiplier: one multiplier bit per cycle, LSB first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (mul_start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, bus.D0_i};
            mplier <= bus.D1_i;
            cnt    <= '0;
        end else if ((state == MUL) && !mul_last) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Result register: loads only when entering DONE, otherwise holds.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q     <= '0;
            carry <= 1'b0;
            zero  <= 1'b1;
            ovf   <= 1'b0;
            err   <= 1'b0;
        end else if (alu_load) begin
            q     <= alu_q;
            carry <= alu_carry;
            zero  <= (alu_q == '0);
            ovf   <= 1'b0;
            err   <= alu_err;
        end else if (mul_last) begin
            q     <= acc[WIDTH-1:0];
            carry <= 1'b0;
            zero  <= (acc[WIDTH-1:0] == '0);
            ovf   <= |acc[2*WIDTH-1:WIDTH];
            err   <= 1'b0;
        end
    end

    assign bus.Ready_o = ready;
    assign bus.Valid_o = valid;
    assign bus.Q_o     = q;
    assign bus.Carry_o = carry;
    assign bus.Zero_o  = zero;
    assign bus.Ovf_o   = ovf;
    assign bus.Err_o   = err;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: an 8-bit instance for the main sequence and a
// 16-bit instance for the width-scaled add.
module tb_seq_alu;
    logic clk;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    seq_alu_if #(.WIDTH(8))  bus8 ();
    seq_alu_if #(.WIDTH(16)) bus16 ();

    seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rstn(rstn), .bus(bus8));
    seq_alu #(.WIDTH(16)) dut16 (.clk(clk), .rstn(rstn), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge, then scramble the inputs so
    // any late sampling shows up in the result.
    task automatic issue8(input logic [2:0] sel, input logic [7:0] d0, input logic [7:0] d1);
        bus8.Sel_i   = sel;
        bus8.D0_i    = d0;
        bus8.D1_i    = d1;
        bus8.Valid_i = 1'b1;
        tick(1);
        bus8.Valid_i = 1'b0;
        bus8.Sel_i   = ~sel;
        bus8.D0_i    = ~d0;
        bus8.D1_i    = d1 ^ 8'h5A;
    endtask

    task automatic expect8(input string tag, input logic [7:0] q, input logic c,
                           input logic z, input logic o, input logic e);
        check({tag, ".valid"}, bus8.Valid_o, 1);
        check({tag, ".q"},     bus8.Q_o,     q);
        check({tag, ".carry"}, bus8.Carry_o, c);
        check({tag, ".zero"},  bus8.Zero_o,  z);
        check({tag, ".ovf"},   bus8.Ovf_o,   o);
        check({tag, ".err"},   bus8.Err_o,   e);
    endtask

    task automatic issue16(input logic [2:0] sel, input logic [15:0] d0, input logic [15:0] d1);
        bus16.Sel_i   = sel;
        bus16.D0_i    = d0;
        bus16.D1_i    = d1;
        bus16.Valid_i = 1'b1;
        tick(1);
        bus16.Valid_i = 1'b0;
        bus16.D0_i    = ~d0;
        bus16.D1_i    = ~d1;
    endtask

    initial begin
        rstn          = 1'b1;
        bus8.Sel_i    = 3'd0;
        bus8.D0_i     = '0;
        bus8.D1_i     = '0;
        bus8.Valid_i  = 1'b0;
        bus8.Ready_i  = 1'b1;
        bus16.Sel_i   = 3'd0;
        bus16.D0_i    = '0;
        bus16.D1_i    = '0;
        bus16.Valid_i = 1'b0;
        bus16.Ready_i = 1'b1;

        // Asynchronous reset values, before any clock edge.
        #1 rstn = 1'b0;
        #1;
        check("rst.ready", bus8.Ready_o, 1);
        check("rst.valid", bus8.Valid_o, 0);
        check("rst.q",     bus8.Q_o,     0);
        check("rst.carry", bus8.Carry_o, 0);
        check("rst.zero",  bus8.Zero_o,  1);
        check("rst.ovf",   bus8.Ovf_o,   0);
        check("rst.err",   bus8.Err_o,   0);
        tick(2);
        rstn = 1'b1;
        tick(1);
        check("post_rst.ready", bus8.Ready_o, 1);

        // Add with carry-out, latency 1, then back to idle with result held.
        issue8(3'd1, 8'hF0, 8'h20);
        expect8("add", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        check("add_idle.ready", bus8.Ready_o, 1);
        check("add_idle.valid", bus8.Valid_o, 0);
        check("add_idle.q",     bus8.Q_o,     8'h10);
        check("add_idle.carry", bus8.Carry_o, 1);

        // Subtract: equal operands, then borrow.
        issue8(3'd3, 8'h05, 8'h05);
        expect8("sub_eq", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1);
        issue8(3'd3, 8'h03, 8'h05);
        expect8("sub_borrow", 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);

        // Multiply 0x10*0x11 = 0x0110: busy for 9 cycles, result at cycle 9.
        issue8(3'd2, 8'h10, 8'h11);
        check("mul_busy.q_hold", bus8.Q_o, 8'hFE);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("mul_busy%0d.ready", i), bus8.Ready_o, 0);
            check($sformatf("mul_busy%0d.valid", i), bus8.Valid_o, 0);
            tick(1);
        end
        expect8("mul_ovf", 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1);

        // Multiply 0x0F*0x0F = 0x00E1, no overflow.
        issue8(3'd2, 8'h0F, 8'h0F);
        tick(9);
        expect8("mul_e1", 8'hE1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);

        // Backpressure: result held for 5 cycles; a request pulse is dropped.
        bus8.Ready_i = 1'b0;
        issue8(3'd1, 8'h12, 8'h34);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d.q", i),     bus8.Q_o,     8'h46);
            check($sformatf("bp%0d.valid", i), bus8.Valid_o, 1);
            check($sformatf("bp%0d.ready", i), bus8.Ready_o, 0);
            check($sformatf("bp%0d.zero", i),  bus8.Zero_o,  0);
            bus8.Valid_i = (i == 2);
            bus8.Sel_i   = 3'd0;
            bus8.D0_i    = 8'hAA;
            tick(1);
        end
        bus8.Valid_i = 1'b0;
        bus8.Ready_i = 1'b1;
        tick(1);
        check("bp_release.ready", bus8.Ready_o, 1);
        check("bp_release.valid", bus8.Valid_o, 0);
        check("bp_release.q",     bus8.Q_o,     8'h46);
        tick(1);
        check("bp_noqueue.valid", bus8.Valid_o, 0);
        check("bp_noqueue.ready", bus8.Ready_o, 1);

        // Shifts (amount truncated to 3 bits), shift by zero, illegal ops, pass.
        issue8(3'd4, 8'h81, 8'h09);
        expect8("shl", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        issue8(3'd5, 8'h81, 8'h09);
        expect8("shr", 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        issue8(3'd4, 8'h5A, 8'h08);
        expect8("shl0", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        issue8(3'd7, 8'h33, 8'h44);
        expect8("ill7", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(1);
        issue8(3'd6, 8'hFF, 8'hFF);
        expect8("ill6", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(1);
        issue8(3'd0, 8'h3C, 8'h00);
        expect8("pass", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);

        // Reset in the middle of a multiply: immediate reset values, no result.
        issue8(3'd2, 8'hFF, 8'hFF);
        tick(3);
        check("midrst_pre.ready", bus8.Ready_o, 0);
        rstn = 1'b0;
        #1;
        check("midrst.ready", bus8.Ready_o, 1);
        check("midrst.valid", bus8.Valid_o, 0);
        check("midrst.q",     bus8.Q_o,     0);
        check("midrst.zero",  bus8.Zero_o,  1);
        check("midrst.carry", bus8.Carry_o, 0);
        check("midrst.ovf",   bus8.Ovf_o,   0);
        check("midrst.err",   bus8.Err_o,   0);
        tick(1);
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check($sformatf("midrst_after%0d.valid", i), bus8.Valid_o, 0);
            check($sformatf("midrst_after%0d.ready", i), bus8.Ready_o, 1);
        end

        // 16-bit instance: same add has no carry at this width; then a carry case.
        issue16(3'd1, 16'h00F0, 16'h0020);
        check("add16.valid", bus16.Valid_o, 1);
        check("add16.q",     bus16.Q_o,     16'h0110);
        check("add16.carry", bus16.Carry_o, 0);
        check("add16.zero",  bus16.Zero_o,  0);
        tick(1);
        check("add16_idle.ready", bus16.Ready_o, 1);
        check("add16_idle.valid", bus16.Valid_o, 0);
        issue16(3'd1, 16'hFFF0, 16'h0020);
        check("add16c.valid", bus16.Valid_o, 1);
        check("add16c.q",     bus16.Q_o,     16'h0010);
        check("add16c.carry", bus16.Carry_o, 1);
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
